// File: rtl/layer7_weight_loader.sv
// Streams packed 32-bit source words into a 16-bit weight memory, low half first,
// with a range-checked start and a registered write port.
module layer7_weight_loader #(
  parameter int WEIGHT_NUM = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [15:0] weight_count,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        write_weight_signal,
  output logic [15:0] write_weight_addr,
  output logic [15:0] write_weight_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;

  state_t      state_q, state_d;
  logic [15:0] base_q, count_q, words_need_q, words_acc_q, issue_cnt_q;
  logic [31:0] hold_q;
  logic        hold_vld_q, half_q;
  logic        p_vld_q;
  logic [15:0] p_addr_q, p_data_q;
  logic        wr_sig_q;
  logic [15:0] wr_addr_q, wr_data_q;
  logic        err_q;

  logic range_ok, start_load, start_zero, start_bad;
  logic issue, last_half, xfer;

  assign range_ok   = ({1'b0, base_addr} + {1'b0, weight_count}) <= 17'(WEIGHT_NUM);
  assign start_zero = (state_q == IDLE) && start && (weight_count == 16'd0);
  assign start_load = (state_q == IDLE) && start && (weight_count != 16'd0) && range_ok;
  assign start_bad  = (state_q == IDLE) && start && (weight_count != 16'd0) && !range_ok;

  assign issue     = (state_q == LOAD) && hold_vld_q;
  // An odd count ends on a low half; the matching high half is never issued.
  assign last_half = issue && (half_q || ((issue_cnt_q + 16'd1) == count_q));
  assign in_ready  = (state_q == LOAD) && (words_acc_q < words_need_q) &&
                     (!hold_vld_q || (half_q && issue));
  assign xfer      = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_load)      state_d = LOAD;
        else if (start_zero) state_d = FINISH;
      end
      // Leave once the last issued half has drained through the output register.
      LOAD:    if ((issue_cnt_q == count_q) && !p_vld_q && !hold_vld_q) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == FINISH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q       <= '0;
      count_q      <= '0;
      words_need_q <= '0;
      words_acc_q  <= '0;
      issue_cnt_q  <= '0;
      hold_q       <= '0;
      hold_vld_q   <= 1'b0;
      half_q       <= 1'b0;
      p_vld_q      <= 1'b0;
      p_addr_q     <= '0;
      p_data_q     <= '0;
      wr_sig_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      if (start_load || start_zero) err_q <= 1'b0;
      else if (start_bad)           err_q <= 1'b1;

      p_vld_q  <= issue;
      wr_sig_q <= p_vld_q;
      if (p_vld_q) begin
        wr_addr_q <= p_addr_q;
        wr_data_q <= p_data_q;
      end

      if (start_load) begin
        base_q       <= base_addr;
        count_q      <= weight_count;
        words_need_q <= 16'(({1'b0, weight_count} + 17'd1) >> 1);
        words_acc_q  <= '0;
        issue_cnt_q  <= '0;
        hold_vld_q   <= 1'b0;
        half_q       <= 1'b0;
      end else begin
        if (issue) begin
          p_addr_q    <= base_q + issue_cnt_q;
          p_data_q    <= half_q ? hold_q[31:16] : hold_q[15:0];
          issue_cnt_q <= issue_cnt_q + 16'd1;
          if (last_half) hold_vld_q <= 1'b0;
          else           half_q     <= 1'b1;
        end
        if (xfer) begin
          hold_q      <= in_data;
          hold_vld_q  <= 1'b1;
          half_q      <= 1'b0;
          words_acc_q <= words_acc_q + 16'd1;
        end
      end
    end
  end

  assign write_weight_signal = wr_sig_q;
  assign write_weight_addr   = wr_addr_q;
  assign write_weight_data   = wr_data_q;
  assign err                 = err_q;

endmodule

// File: tb/tb_layer7_weight_loader.sv
// Randomized bench for layer7_weight_loader: expected writes, timing and memory
// contents are derived from the source words and the documented latency rules.
module tb_layer7_weight_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] weight_count = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, write_weight_signal, busy, done, err;
  logic [15:0] write_weight_addr, write_weight_data;

  layer7_weight_loader #(.WEIGHT_NUM(2000)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .weight_count(weight_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .write_weight_signal(write_weight_signal),
    .write_weight_addr(write_weight_addr), .write_weight_data(write_weight_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int start_edge = 0;
  int done_cnt = 0, done_cyc = 0, busy_cnt = 0;
  int wr_addr_q[$], wr_data_q[$], wr_edge_q[$];
  int xfer_edge_q[$];
  logic [31:0] src_q[$];
  logic [15:0] mem [0:1999];
  int wcnt [0:1999];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (write_weight_signal) begin
        wr_addr_q.push_back(int'(write_weight_addr));
        wr_data_q.push_back(int'(write_weight_data));
        wr_edge_q.push_back(cyc);
        if (write_weight_addr < 16'd2000) begin
          mem[write_weight_addr] = write_weight_data;
          wcnt[write_weight_addr]++;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_cnt++;
    end
  end

  task automatic clear_obs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_edge_q.delete(); xfer_edge_q.delete();
    done_cnt = 0; busy_cnt = 0; done_cyc = -1;
  endtask

  task automatic fill_random(input int n);
    src_q.delete();
    for (int i = 0; i < n; i++) src_q.push_back($urandom);
  endtask

  task automatic start_pulse(input int b, input int c);
    @(negedge clk);
    base_addr = 16'(b); weight_count = 16'(c); start = 1'b1;
    start_edge = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called on a falling edge; offers words with random gaps and logs the edge of each transfer.
  task automatic feed(input int gap, input bit tail);
    int idx = 0;
    int t = 0;
    while (idx < src_q.size() && t < 20000) begin
      in_data  = src_q[idx];
      in_valid = ($urandom_range(99) >= gap);
      #1;
      if (in_valid && in_ready) begin
        xfer_edge_q.push_back(cyc + 1);
        idx++;
      end
      t++;
      @(negedge clk);
    end
    chk("feed_words_taken", idx, src_q.size());
    if (tail) begin
      for (int i = 0; i < 2; i++) begin
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        #1;
        chk("ready_after_last_word", in_ready, 1'b0);
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [15:0] exp_weight(input int k);
    logic [31:0] w;
    w = src_q[k / 2];
    return (k % 2 == 1) ? w[31:16] : w[15:0];
  endfunction

  task automatic check_writes(input int b, input int c);
    int exp_done;
    chk("wr_count", wr_addr_q.size(), c);
    for (int k = 0; k < wr_addr_q.size() && k < c; k++) begin
      chk("wr_addr", wr_addr_q[k], b + k);
      chk("wr_data", wr_data_q[k], {16'd0, exp_weight(k)});
      if (xfer_edge_q.size() > k / 2)
        chk("wr_edge", wr_edge_q[k], xfer_edge_q[k / 2] + 2 + (k % 2));
    end
    chk("done_cnt", done_cnt, 1);
    if (c == 0 || xfer_edge_q.size() > (c - 1) / 2) begin
      exp_done = (c == 0) ? start_edge : xfer_edge_q[(c - 1) / 2] + 2 + ((c - 1) % 2) + 1;
      chk("done_cyc", done_cyc, exp_done);
      chk("busy_cycles", busy_cnt, exp_done - start_edge + 1);
    end
    chk("err_after_load", err, 1'b0);
  endtask

  task automatic run_load(input int b, input int c, input int gap);
    int t = 0;
    clear_obs();
    start_pulse(b, c);
    feed(gap, 1'b1);
    while (done_cnt == 0 && t < 200) begin
      @(negedge clk); #1; t++;
    end
    repeat (3) @(negedge clk);
    #1;
    check_writes(b, c);
  endtask

  initial begin
    int bad;
    int c;
    int b;
    int n_at_rst;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_wr_sig", write_weight_signal, 1'b0);
    chk("rst_wr_addr", write_weight_addr, 16'd0);
    chk("rst_wr_data", write_weight_data, 16'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Even count, back-to-back words
    src_q.delete(); src_q.push_back(32'h0002_0001); src_q.push_back(32'h0004_0003);
    run_load(0, 4, 0);

    // Odd count drops the final high half
    src_q.delete(); src_q.push_back(32'hBBBB_AAAA); src_q.push_back(32'hDDDD_CCCC);
    run_load(100, 3, 0);

    // Out-of-range start, then exactly-fitting load at the top of memory
    clear_obs();
    start_pulse(1990, 11);
    #1;
    chk("range_err_set", err, 1'b1);
    chk("range_err_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("range_err_writes", wr_addr_q.size(), 0);
    chk("range_err_sticky", err, 1'b1);
    fill_random(5);
    run_load(1990, 10, 0);
    if (wr_addr_q.size() > 0) chk("top_last_addr", wr_addr_q[wr_addr_q.size() - 1], 1999);

    // Zero-length load
    src_q.delete();
    run_load(50, 0, 0);

    for (int i = 0; i < 6; i++) begin
      c = $urandom_range(1, 40);
      b = $urandom_range(0, 2000 - c);
      fill_random((c + 1) / 2);
      run_load(b, c, $urandom_range(0, 60));
    end

    // Full memory with random gaps
    for (int a = 0; a < 2000; a++) begin mem[a] = '0; wcnt[a] = 0; end
    fill_random(1000);
    run_load(0, 2000, 30);
    bad = 0;
    for (int a = 0; a < 2000; a++)
      if (wcnt[a] != 1 || mem[a] !== exp_weight(a)) bad++;
    chk("mem_readback_bad", bad, 0);

    // Reset in the middle of a load
    clear_obs();
    fill_random(4);
    start_pulse(200, 8);
    feed(0, 1'b0);
    #1;
    chk("abort_writes_before_rst", wr_addr_q.size(), 5);
    n_at_rst = wr_addr_q.size();
    rst = 1'b1;
    #1;
    chk("abort_in_ready", in_ready, 1'b0);
    chk("abort_wr_sig", write_weight_signal, 1'b0);
    chk("abort_wr_addr", write_weight_addr, 16'd0);
    chk("abort_wr_data", write_weight_data, 16'd0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("abort_no_more_writes", wr_addr_q.size(), n_at_rst);
    chk("abort_no_done", done_cnt, 0);
    for (int k = 0; k < wr_addr_q.size() && k < 8; k++) begin
      chk("abort_wr_addr_k", wr_addr_q[k], 200 + k);
      chk("abort_wr_data_k", wr_data_q[k], {16'd0, exp_weight(k)});
    end
    fill_random(1);
    run_load(300, 2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
